// File: rtl/tansig_scheduler_pkg.sv
// Shared definitions for the tanh request scheduler: Q16.16 constants and FSM states.
package tansig_scheduler_pkg;

    // Q16.16 representations of +1.0 and -1.0 (the tanh saturation rails).
    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_0000;

    // IDLE: nothing in flight. ADDR: LUT registers its address. CAPT: LUT result is valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/tansig_scheduler_act_rsp_fifo.sv
// Small synchronous result FIFO: combinational head, occupancy count, power-of-two depth.
module act_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Guard both ends so a misbehaving caller can never corrupt the pointers.
    assign push_ok   = push && (count_reg != (AW+1)'(DEPTH));
    assign pop_ok    = pop && (count_reg != '0);
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tansig_scheduler.sv
// Round-robin scheduler sharing one external tanh_lut between NREQ requesters,
// returning tagged results in grant order through a credit-protected FIFO.
module tansig_scheduler
    import tansig_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic [N-1:0]    lut_phase,
    input  logic [N-1:0]    lut_tanh,
    output logic            rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic [N-1:0]    rsp_data,
    input  logic            rsp_ready,
    output logic            busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Reject parameter sets the datapath cannot represent.
    if (((DEPTH & (DEPTH - 1)) != 0) || (Q >= N)) begin : g_bad_params
        $error("tansig_scheduler: DEPTH must be a power of two and Q < N");
    end

    logic [N-1:0]    req_word [NREQ];
    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   rr_ptr_reg;
    logic [IW-1:0]   id_reg;
    logic [N-1:0]    phase_reg;
    logic [IW-1:0]   win_idx;
    logic            any_valid;
    logic            credit;
    logic            grant;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [IW+N-1:0] fifo_head;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*N +: N];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_idx   = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    // The in-flight operation already owns a FIFO slot; a pop this cycle frees nothing yet.
    assign credit    = (int'(fifo_count) + ((state_reg != IDLE) ? 1 : 0)) < DEPTH;
    assign grant     = !rst && (state_reg != ADDR) && any_valid && credit;
    assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;

    // Next-state logic: each grant occupies the LUT for exactly ADDR then CAPT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = grant ? ADDR : IDLE;
            ADDR:    state_next = CAPT;
            CAPT:    state_next = grant ? ADDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture and pointer advance; phase stays stable across ADDR and CAPT.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            phase_reg  <= '0;
            id_reg     <= '0;
        end else if (grant) begin
            phase_reg  <= req_word[win_idx];
            id_reg     <= win_idx;
            rr_ptr_reg <= IW'((int'(win_idx) + 1) % NREQ);
        end
    end

    // A reset landing in CAPT must drop the result rather than push it.
    assign fifo_push = (state_reg == CAPT) && !rst;
    assign fifo_pop  = rsp_valid && rsp_ready;

    act_rsp_fifo #(
        .WIDTH (IW + N),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({id_reg, lut_tanh}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign lut_phase = phase_reg;
    assign rsp_valid = !rst && !fifo_empty;
    assign rsp_id    = fifo_head[N +: IW];
    assign rsp_data  = fifo_head[N-1:0];
    assign busy      = !rst && ((state_reg != IDLE) || !fifo_empty);

endmodule

// File: tb/tb_tansig_scheduler.sv
// Self-checking bench for tansig_scheduler: directed scenarios plus a randomized
// run against a grant/credit/ordering reference model. The shared LUT is modelled
// as a simple saturating tanh approximation driven from the live phase.
module tb_tansig_scheduler;
    import tansig_scheduler_pkg::*;

    localparam int NREQ  = 4;
    localparam int N     = 32;
    localparam int Q     = 16;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      lut_phase;
    logic [N-1:0]      lut_tanh;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [N-1:0]      rsp_data;
    logic              rsp_ready;
    logic              busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    tansig_scheduler #(
        .NREQ(NREQ), .N(N), .Q(Q), .DEPTH(DEPTH), .IW(IW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .lut_phase(lut_phase), .lut_tanh(lut_tanh),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Saturating tanh stand-in: +-1.0 beyond |x| >= 2.0, x/2 in between.
    function automatic logic [31:0] tanh_ref(input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        if (s >= 32'sh0002_0000) return ONE;
        if (s <= -32'sh0002_0000) return NEG_ONE;
        return 32'(s >>> 1);
    endfunction

    always_comb lut_tanh = tanh_ref(lut_phase);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = {$urandom, $urandom, $urandom, $urandom}; rsp_ready = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
            tests++; if (lut_phase !== 32'h0) begin fails++; $display("FAIL reset_phase: got %h want 0", lut_phase); end
            next_cycle();
        end
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        next_cycle();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_data[0 +: N] = 32'h0004_0000;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        next_cycle();
        req_valid = '0; req_data = '0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            tests++; if (lut_phase !== 32'h0004_0000) begin fails++; $display("FAIL single_phase_t%0d: got %h want 00040000", c, lut_phase); end
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early_rsp_t%0d: got %b want 0", c, rsp_valid); end
            next_cycle();
        end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
        tests++; if (rsp_data !== ONE) begin fails++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, ONE); end
        $display("[TB] rsp id=%0d data=%h", rsp_id, rsp_data);
        next_cycle();
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_drained: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
        next_cycle();
    endtask

    task automatic test_neg_sat();
        do_reset();
        req_valid = 4'b0100; req_data[2*N +: N] = 32'hFFFC_0000;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL negsat_grant: got %b want 0100", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL negsat_rsp_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL negsat_rsp_id: got %0d want 2", rsp_id); end
        tests++; if (rsp_data !== NEG_ONE) begin fails++; $display("FAIL negsat_rsp_data: got %h want %h", rsp_data, NEG_ONE); end
        $display("[TB] rsp id=%0d data=%h", rsp_id, rsp_data);
        next_cycle();
    endtask

    task automatic test_all_four();
        logic [31:0] ph [NREQ];
        int got_id [8];
        logic [31:0] got_data [8];
        int n = 0;
        do_reset();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            ph[i] = $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000;
            req_data[i*N +: N] = ph[i];
        end
        for (int c = 0; c < 12; c++) begin
            logic [NREQ-1:0] exp_rdy;
            if (c == 7) req_valid = '0;
            exp_rdy = (c <= 6 && c % 2 == 0) ? NREQ'(1) << (c / 2) : '0;
            @(negedge clk);
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL all4_grant_c%0d: got %b want %b", c, req_ready, exp_rdy); end
            if (rsp_valid && n < 8) begin
                got_id[n] = int'(rsp_id); got_data[n] = rsp_data; n++;
                $display("[TB] rsp id=%0d data=%h", rsp_id, rsp_data);
            end
            next_cycle();
        end
        tests++; if (n !== 4) begin fails++; $display("FAIL all4_count: got %0d want 4", n); end
        for (int k = 0; k < 4 && k < n; k++) begin
            tests++; if (got_id[k] !== k || got_data[k] !== tanh_ref(ph[k])) begin
                fails++; $display("FAIL all4_order_%0d: got id=%0d data=%h want id=%0d data=%h", k, got_id[k], got_data[k], k, tanh_ref(ph[k]));
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 4'b0101;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 12; c++) begin
            logic [NREQ-1:0] exp_rdy;
            exp_rdy = (c % 2 != 0) ? 4'b0000 : (((c / 2) % 2 == 0) ? 4'b0001 : 4'b0100);
            @(negedge clk);
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL fair_grant_c%0d: got %b want %b", c, req_ready, exp_rdy); end
            next_cycle();
        end
        req_valid = '0;
        repeat (6) next_cycle();
        $display("[TB] test_fairness done");
    endtask

    task automatic test_backpressure();
        int accepts = 0;
        do_reset();
        rsp_ready = 1'b0; req_valid = 4'b0001;
        for (int c = 0; c < 14; c++) begin
            logic [NREQ-1:0] exp_rdy;
            req_data[0 +: N] = 32'(c) * 32'h1000;
            exp_rdy = (c <= 6 && c % 2 == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL bp_grant_c%0d: got %b want %b", c, req_ready, exp_rdy); end
            if (req_ready[0]) accepts++;
            next_cycle();
        end
        tests++; if (accepts !== 4) begin fails++; $display("FAIL bp_accepts: got %0d want 4", accepts); end
        req_valid = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                tests++; if (rsp_valid !== 1'b1 || rsp_data !== tanh_ref(32'(2 * c) * 32'h1000)) begin
                    fails++; $display("FAIL bp_drain_%0d: got valid=%b data=%h want 1 %h", c, rsp_valid, rsp_data, tanh_ref(32'(2 * c) * 32'h1000));
                end
                $display("[TB] rsp id=%0d data=%h", rsp_id, rsp_data);
            end else begin
                tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
            end
            next_cycle();
        end
        req_valid = 4'b0001;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_resume: got %b want 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        repeat (5) next_cycle();
    endtask

    task automatic test_reset_capt();
        do_reset();
        req_valid = 4'b0010; req_data[1*N +: N] = 32'h0000_8000;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rstcapt_grant: got %b want 0010", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rstcapt_during: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rstcapt_after_c%0d: busy=%b rsp_valid=%b want 0 0", c, busy, rsp_valid); end
            next_cycle();
        end
        $display("[TB] test_reset_capt done");
    endtask

    task automatic test_random();
        exp_t q[$];
        int m_rr = 0;
        int m_out = 0;
        bit m_last = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            logic [NREQ-1:0] exp_rdy;
            int g;
            bit exp_rv;
            if (cyc < 400) begin
                req_valid = NREQ'($urandom);
                for (int i = 0; i < NREQ; i++)
                    req_data[i*N +: N] = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 32'h0005_FFFF) - 32'h0003_0000);
                rsp_ready = (cyc % 80 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = '0; rsp_ready = 1'b1;
            end
            g = -1;
            if (!m_last && m_out < DEPTH)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
            exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
            exp_rv = (q.size() > 0) && (q[0].due <= cyc);
            @(negedge clk);
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rand_grant_c%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            tests++; if (rsp_valid !== exp_rv) begin fails++; $display("FAIL rand_rsp_valid_c%0d: got %b want %b", cyc, rsp_valid, exp_rv); end
            if (exp_rv) begin
                tests++; if (rsp_id !== IW'(q[0].id) || rsp_data !== q[0].data) begin
                    fails++; $display("FAIL rand_rsp_c%0d: got id=%0d data=%h want id=%0d data=%h", cyc, rsp_id, rsp_data, q[0].id, q[0].data);
                end
                if (rsp_ready) begin
                    $display("[TB] rsp id=%0d data=%h", q[0].id, q[0].data);
                    void'(q.pop_front());
                    m_out--;
                end
            end
            if (g >= 0) begin
                q.push_back('{g, tanh_ref(req_data[g*N +: N]), cyc + 3});
                m_out++;
                m_rr = (g + 1) % NREQ;
                m_last = 1'b1;
            end else begin
                m_last = 1'b0;
            end
            next_cycle();
        end
        @(negedge clk);
        tests++; if (q.size() !== 0 || busy !== 1'b0) begin fails++; $display("FAIL rand_final: pending=%0d busy=%b want 0 0", q.size(), busy); end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_neg_sat();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_reset_capt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
